// File: rtl/mem_port_arbiter.sv
// Serialises per-channel read/write requests onto one backend command port,
// with round-robin or fixed-priority selection and one transaction in flight.
module mem_port_arbiter #(
   parameter int NCH       = 4,
   parameter int AW        = 22,
   parameter int DW        = 32,
   parameter int PRIO_MODE = 0
) (
   input  logic                     sdram_clk,
   input  logic                     reset_n,
   input  logic [NCH-1:0]           ch_req,
   input  logic [NCH-1:0]           ch_write,
   input  logic [NCH*AW-1:0]        ch_addr,
   input  logic [NCH*DW-1:0]        ch_data_in,
   output logic [DW-1:0]            ch_data_out,
   output logic [NCH-1:0]           ch_ready,
   output logic [NCH-1:0]           ch_done,
   output logic                     mem_cmd_valid,
   output logic                     mem_cmd_write,
   output logic [AW-1:0]            mem_cmd_addr,
   output logic [DW-1:0]            mem_wdata,
   input  logic                     mem_cmd_ack,
   input  logic [DW-1:0]            mem_rdata,
   input  logic                     mem_rdata_valid,
   input  logic                     mem_wr_done,
   output logic [$clog2(NCH)-1:0]   grant_id,
   output logic                     busy
);
   localparam int GW = $clog2(NCH);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, RETIRE} state_t;

   state_t           state_q, state_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic [GW-1:0]    lastGrant_q, lastGrant_d;
   logic [NCH-1:0]   retireMask_q, retireMask_d;
   logic             isWrite_q, isWrite_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   logic [DW-1:0]    rdata_q, rdata_d;

   logic [NCH-1:0]   eligible;
   logic             found;
   logic [GW-1:0]    winner;
   logic [GW:0]      candWide;
   logic [GW-1:0]    cand;

   // Walk candidates from the back of the search order so the first eligible one wins.
   always_comb begin
      eligible = (ch_req | ch_write) & ~retireMask_q;
      found    = 1'b0;
      winner   = '0;
      candWide = '0;
      cand     = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (PRIO_MODE != 0) begin
            candWide = (GW+1)'(k);
         end else begin
            candWide = (GW+1)'(lastGrant_q) + (GW+1)'(k) + (GW+1)'(1);
         end
         if (candWide >= (GW+1)'(NCH)) begin
            candWide = candWide - (GW+1)'(NCH);
         end
         cand = candWide[GW-1:0];
         if (eligible[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      lastGrant_d  = lastGrant_q;
      isWrite_d    = isWrite_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      retireMask_d = retireMask_q & (ch_req | ch_write);
      mem_cmd_valid = 1'b0;
      ch_ready     = '0;
      ch_done      = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d   = winner;
               addr_d    = ch_addr[winner*AW +: AW];
               wdata_d   = ch_data_in[winner*DW +: DW];
               isWrite_d = ch_write[winner];
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            mem_cmd_valid = 1'b1;
            if (mem_cmd_ack) begin
               state_d = isWrite_q ? WAIT_WR : WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (mem_rdata_valid) begin
               rdata_d = mem_rdata;
               state_d = RETIRE;
            end
         end
         WAIT_WR: begin
            if (mem_wr_done) begin
               state_d = RETIRE;
            end
         end
         RETIRE: begin
            // Masking the served channel keeps a still-held request from being served twice.
            if (isWrite_q) begin
               ch_done[grant_q] = 1'b1;
            end else begin
               ch_ready[grant_q] = 1'b1;
            end
            retireMask_d[grant_q] = 1'b1;
            lastGrant_d = grant_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sdram_clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         lastGrant_q  <= GW'(NCH - 1);
         retireMask_q <= '0;
         isWrite_q    <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         lastGrant_q  <= lastGrant_d;
         retireMask_q <= retireMask_d;
         isWrite_q    <= isWrite_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
      end
   end

   assign mem_cmd_write = mem_cmd_valid & isWrite_q;
   assign mem_cmd_addr  = addr_q;
   assign mem_wdata     = wdata_q;
   assign ch_data_out   = rdata_q;
   assign grant_id      = grant_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: randomized request batches against a
// transaction-level ordering/memory model, plus a fixed-priority instance.
module tb_mem_port_arbiter;
   localparam int NCH = 4;
   localparam int AW  = 22;
   localparam int DW  = 32;

   typedef struct {
      int               ch;
      logic             wr;
      logic [AW-1:0]    addr;
      logic [DW-1:0]    data;
   } txn_t;

   logic               sdram_clk;
   logic               reset_n;
   logic [NCH-1:0]     chReq, chWrite;
   logic [NCH*AW-1:0]  chAddr;
   logic [NCH*DW-1:0]  chDataIn;
   logic [DW-1:0]      chDataOut;
   logic [NCH-1:0]     chReady, chDone;
   logic               memCmdValid, memCmdWrite, memCmdAck;
   logic [AW-1:0]      memCmdAddr;
   logic [DW-1:0]      memWdata, memRdata;
   logic               memRdataValid, memWrDone;
   logic [1:0]         grantId;
   logic               busy;

   logic [NCH-1:0]     fxReq;
   logic [NCH*AW-1:0]  fxAddr;
   logic [DW-1:0]      fxDataOut;
   logic [NCH-1:0]     fxReady, fxDone;
   logic               fxValid, fxCmdWrite;
   logic [AW-1:0]      fxCmdAddr;
   logic [DW-1:0]      fxWdata;
   logic [1:0]         fxGrant;
   logic               fxBusy;

   int checks = 0;
   int errors = 0;

   txn_t cmdQ[$];
   txn_t cplQ[$];

   logic [DW-1:0] modelMem[16];
   logic [DW-1:0] beMem[16];
   int            modelLast;
   logic [DW-1:0] modelLastRead;

   logic [AW-1:0] bAddr[NCH];
   logic [DW-1:0] bData[NCH];
   int            bKind[NCH];
   int            holdForce;
   logic [NCH-1:0] active, seenCpl, dropEarly;
   int            holdCnt[NCH];

   int            beMode, fixedDelay, bePending, beDelay;
   logic [3:0]    beAddr;
   logic          ackR, rvR, wdR;
   logic [DW-1:0] rdataR;

   mem_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .PRIO_MODE(0)) dut (
      .sdram_clk(sdram_clk), .reset_n(reset_n),
      .ch_req(chReq), .ch_write(chWrite), .ch_addr(chAddr), .ch_data_in(chDataIn),
      .ch_data_out(chDataOut), .ch_ready(chReady), .ch_done(chDone),
      .mem_cmd_valid(memCmdValid), .mem_cmd_write(memCmdWrite),
      .mem_cmd_addr(memCmdAddr), .mem_wdata(memWdata), .mem_cmd_ack(memCmdAck),
      .mem_rdata(memRdata), .mem_rdata_valid(memRdataValid), .mem_wr_done(memWrDone),
      .grant_id(grantId), .busy(busy)
   );

   mem_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .PRIO_MODE(1)) dutFixed (
      .sdram_clk(sdram_clk), .reset_n(reset_n),
      .ch_req(fxReq), .ch_write('0), .ch_addr(fxAddr), .ch_data_in('0),
      .ch_data_out(fxDataOut), .ch_ready(fxReady), .ch_done(fxDone),
      .mem_cmd_valid(fxValid), .mem_cmd_write(fxCmdWrite),
      .mem_cmd_addr(fxCmdAddr), .mem_wdata(fxWdata), .mem_cmd_ack(fxValid),
      .mem_rdata(32'h5A5A_0001), .mem_rdata_valid(1'b1), .mem_wr_done(1'b1),
      .grant_id(fxGrant), .busy(fxBusy)
   );

   // Backend responder: zero-wait when beMode is 0, otherwise randomized latency.
   assign memCmdAck     = (beMode == 0) ? memCmdValid : ackR;
   assign memRdataValid = (beMode == 0) ? 1'b1 : rvR;
   assign memWrDone     = (beMode == 0) ? 1'b1 : wdR;
   assign memRdata      = rdataR;

   initial sdram_clk = 1'b0;
   always #5 sdram_clk = ~sdram_clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Backend memory model: services accepted commands and injects stray responses.
   initial begin
      ackR = 0; rvR = 0; wdR = 0; rdataR = '0; bePending = 0; beDelay = 0; beAddr = '0;
      forever begin
         @(posedge sdram_clk); #1;
         ackR = 0; rvR = 0; wdR = 0;
         if (beMode == 0) begin
            if (memCmdValid && memCmdWrite) beMem[memCmdAddr[3:0]] = memWdata;
         end else if (bePending != 0) begin
            if (beDelay == 0) begin
               if (bePending == 1) begin rvR = 1; rdataR = beMem[beAddr]; end
               else wdR = 1;
               bePending = 0;
            end else begin
               beDelay--;
               if ($urandom_range(0, 2) == 0) begin
                  if (bePending == 1) wdR = 1;
                  else begin rvR = 1; rdataR = $urandom; end
               end
            end
         end else if (memCmdValid) begin
            if (fixedDelay >= 0 || $urandom_range(0, 1) == 0) begin
               ackR = 1;
               bePending = memCmdWrite ? 2 : 1;
               beAddr = memCmdAddr[3:0];
               if (memCmdWrite) beMem[beAddr] = memWdata;
               beDelay = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 4));
            end
         end else if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0) begin rvR = 1; rdataR = $urandom; end
            else wdR = 1;
         end
      end
   end

   // Monitor: pops the scoreboard whenever a command is accepted or a pulse appears.
   initial begin : monitor
      txn_t e;
      logic [NCH-1:0] expVec;
      forever begin
         @(negedge sdram_clk);
         if (reset_n) begin
            if (memCmdValid && memCmdAck) begin
               if (cmdQ.size() == 0) begin
                  checks++; errors++;
                  $display("[TB] FAIL unexpected_cmd: grant_id=%0d issued, expected no command", grantId);
               end else begin
                  e = cmdQ.pop_front();
                  checkOutput("cmd_grant", 64'(grantId), 64'(e.ch));
                  checkOutput("cmd_write", 64'(memCmdWrite), 64'(e.wr));
                  checkOutput("cmd_addr", 64'(memCmdAddr), 64'(e.addr));
                  if (e.wr) checkOutput("cmd_wdata", 64'(memWdata), 64'(e.data));
               end
            end
            if ((chReady | chDone) != 0) begin
               if (cplQ.size() == 0) begin
                  checks++; errors++;
                  $display("[TB] FAIL unexpected_pulse: ready=%b done=%b, expected none", chReady, chDone);
               end else begin
                  e = cplQ.pop_front();
                  expVec = NCH'(1) << e.ch;
                  checkOutput("cpl_ready", 64'(chReady), e.wr ? 64'(0) : 64'(expVec));
                  checkOutput("cpl_done", 64'(chDone), e.wr ? 64'(expVec) : 64'(0));
                  checkOutput("cpl_data", 64'(chDataOut), 64'(e.data));
               end
            end
         end
      end
   end

   // One cycle of client behaviour: hold until completion (plus optional extra), or drop early.
   task automatic stepCycle();
      @(posedge sdram_clk); #1;
      for (int i = 0; i < NCH; i++) begin
         if (active[i]) begin
            if (!seenCpl[i] && (chReady[i] || chDone[i])) seenCpl[i] = 1'b1;
            if (seenCpl[i]) begin
               if (holdCnt[i] == 0) begin
                  chReq[i] = 1'b0; chWrite[i] = 1'b0; active[i] = 1'b0;
               end else holdCnt[i]--;
            end else if (dropEarly[i] && memCmdValid && grantId == 2'(i)) begin
               chReq[i] = 1'b0; chWrite[i] = 1'b0;
               chAddr[i*AW +: AW]   = AW'($urandom);
               chDataIn[i*DW +: DW] = $urandom;
            end
         end
      end
   endtask

   // Raise a batch of requests together and predict the service order and results.
   task automatic applyStimulus(input logic [NCH-1:0] sel, input bit fixedPrio, input bit allowEarly);
      int startCh;
      for (int i = 0; i < NCH; i++) begin
         if (sel[i]) begin
            chAddr[i*AW +: AW]   = bAddr[i];
            chDataIn[i*DW +: DW] = bData[i];
            chWrite[i] = (bKind[i] != 0);
            chReq[i]   = (bKind[i] != 1);
            active[i]  = 1'b1;
            seenCpl[i] = 1'b0;
            holdCnt[i] = (holdForce >= 0) ? holdForce : int'($urandom_range(0, 3));
            dropEarly[i] = allowEarly && ($urandom_range(0, 3) == 0);
         end
      end
      startCh = fixedPrio ? 0 : (modelLast + 1) % NCH;
      for (int k = 0; k < NCH; k++) begin
         int c;
         txn_t t;
         c = (startCh + k) % NCH;
         if (sel[c]) begin
            t.ch = c; t.addr = bAddr[c]; t.wr = (bKind[c] != 0);
            if (t.wr) begin
               modelMem[bAddr[c][3:0]] = bData[c];
               t.data = bData[c];
               cmdQ.push_back(t);
               t.data = modelLastRead;
               cplQ.push_back(t);
            end else begin
               modelLastRead = modelMem[bAddr[c][3:0]];
               t.data = '0;
               cmdQ.push_back(t);
               t.data = modelLastRead;
               cplQ.push_back(t);
            end
            modelLast = c;
         end
      end
   endtask

   task automatic waitBatch();
      int n = 0;
      while ((active != 0 || cmdQ.size() != 0 || cplQ.size() != 0) && n < 300) begin
         stepCycle();
         n++;
      end
      if (n >= 300) begin
         checks++; errors++;
         $display("[TB] FAIL batch_timeout: %0d commands and %0d completions outstanding, expected 0", cmdQ.size(), cplQ.size());
         cmdQ.delete(); cplQ.delete();
         active = '0; chReq = '0; chWrite = '0;
      end
      repeat (2) stepCycle();
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      active = '0; chReq = '0; chWrite = '0;
      stepCycle();
      stepCycle();
      cmdQ.delete(); cplQ.delete();
      modelLast = NCH - 1;
      modelLastRead = '0;
      reset_n = 1'b1;
   endtask

   initial begin : stimulus
      int n;
      logic [NCH-1:0] subset;
      int expOrder[$];
      int gotOrder[$];
      logic [AW-1:0] fxAddrV[NCH];

      chReq = '0; chWrite = '0; chAddr = '0; chDataIn = '0;
      fxReq = '0; fxAddr = '0;
      active = '0; seenCpl = '0; dropEarly = '0;
      for (int i = 0; i < NCH; i++) holdCnt[i] = 0;
      for (int i = 0; i < 16; i++) begin
         modelMem[i] = 32'h1000_0000 + 32'(i);
         beMem[i]    = 32'h1000_0000 + 32'(i);
      end
      beMode = 0; fixedDelay = -1; holdForce = 0;
      modelLast = NCH - 1; modelLastRead = '0;
      reset_n = 1'b0;
      repeat (3) @(posedge sdram_clk);
      @(negedge sdram_clk);
      checkOutput("reset_busy", 64'(busy), 64'(0));
      checkOutput("reset_valid", 64'(memCmdValid), 64'(0));
      checkOutput("reset_grant", 64'(grantId), 64'(0));
      checkOutput("reset_data", 64'(chDataOut), 64'(0));
      checkOutput("reset_addr", 64'(memCmdAddr), 64'(0));
      checkOutput("reset_pulses", 64'({chReady, chDone}), 64'(0));
      stepCycle();
      reset_n = 1'b1;
      stepCycle();

      // Single write on channel 1 with a zero-wait backend, checking cycle latency.
      $display("[TB] single write latency");
      bAddr[1] = 22'd4; bData[1] = 32'o30303333; bKind[1] = 1;
      applyStimulus(4'b0010, 1'b0, 1'b0);
      @(negedge sdram_clk);
      checkOutput("lat_n_valid", 64'(memCmdValid), 64'(0));
      stepCycle(); @(negedge sdram_clk);
      checkOutput("lat_n1_valid", 64'(memCmdValid), 64'(1));
      stepCycle(); @(negedge sdram_clk);
      checkOutput("lat_n2_done", 64'(chDone), 64'(0));
      stepCycle(); @(negedge sdram_clk);
      checkOutput("lat_n3_done", 64'(chDone), 64'(4'b0010));
      waitBatch();

      // Read-back of the same word with a slow backend.
      $display("[TB] read-back");
      beMode = 1; fixedDelay = 5;
      bKind[1] = 0;
      applyStimulus(4'b0010, 1'b0, 1'b0);
      waitBatch();
      checkOutput("readback_data", 64'(chDataOut), 64'(32'o30303333));

      // Channel keeps requesting after its pulse; it must not be served again.
      $display("[TB] hold check");
      holdForce = 3; fixedDelay = -1;
      bAddr[2] = 22'h2_0007; bKind[2] = 0;
      applyStimulus(4'b0100, 1'b0, 1'b0);
      waitBatch();

      // Round-robin from reset: all four read together.
      $display("[TB] round-robin from reset");
      doReset();
      stepCycle();
      holdForce = -1;
      for (int i = 0; i < NCH; i++) begin
         bAddr[i] = AW'($urandom); bKind[i] = 0; bData[i] = $urandom;
      end
      applyStimulus(4'b1111, 1'b0, 1'b0);
      waitBatch();
      bKind[0] = 0;
      applyStimulus(4'b0001, 1'b0, 1'b0);
      waitBatch();

      // Randomized batches with mixed kinds, early drops and random latency.
      $display("[TB] random batches");
      for (int b = 0; b < 40; b++) begin
         for (int i = 0; i < NCH; i++) begin
            bAddr[i] = AW'($urandom); bData[i] = $urandom; bKind[i] = $urandom_range(0, 2);
         end
         applyStimulus(4'($urandom_range(1, 15)), 1'b0, 1'b1);
         waitBatch();
      end

      // Reset while waiting for read data; the late response must be ignored.
      $display("[TB] reset in WAIT_RD");
      fixedDelay = 6; holdForce = 0;
      bAddr[2] = 22'd9; bKind[2] = 0;
      applyStimulus(4'b0100, 1'b0, 1'b0);
      n = 0;
      while (bePending == 0 && n < 40) begin stepCycle(); n++; end
      checkOutput("rst_wait_accept", 64'(bePending), 64'(1));
      stepCycle(); stepCycle();
      doReset();
      @(negedge sdram_clk);
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_data", 64'(chDataOut), 64'(0));
      n = 0;
      while (bePending != 0 && n < 20) begin stepCycle(); n++; end
      stepCycle(); @(negedge sdram_clk);
      checkOutput("rst_no_ready", 64'(chReady), 64'(0));
      fixedDelay = -1;
      bAddr[0] = 22'd3; bKind[0] = 0;
      bAddr[2] = 22'd5; bKind[2] = 0;
      applyStimulus(4'b0101, 1'b0, 1'b0);
      waitBatch();

      // Fixed-priority instance: lowest index must always win.
      $display("[TB] fixed priority");
      for (int t = 0; t < 6; t++) begin
         expOrder.delete(); gotOrder.delete();
         subset = (t == 0) ? 4'b1010 : 4'($urandom_range(1, 15));
         for (int i = 0; i < NCH; i++) begin
            fxAddrV[i] = AW'($urandom);
            fxAddr[i*AW +: AW] = fxAddrV[i];
            if (subset[i]) expOrder.push_back(i);
         end
         @(negedge sdram_clk);
         fxReq = subset;
         n = 0;
         while (gotOrder.size() < expOrder.size() && n < 100) begin
            @(negedge sdram_clk);
            n++;
            if (fxValid) begin
               checkOutput("fixed_addr", 64'(fxCmdAddr), 64'(fxAddrV[expOrder[gotOrder.size()]]));
               gotOrder.push_back(int'(fxGrant));
            end
            if (fxReady != 0) fxReq = fxReq & ~fxReady;
         end
         if (n >= 100) begin
            checks++; errors++;
            $display("[TB] FAIL fixed_timeout: %0d grants seen, expected %0d", gotOrder.size(), expOrder.size());
         end
         for (int k = 0; k < gotOrder.size(); k++) begin
            checkOutput("fixed_order", 64'(gotOrder[k]), 64'(expOrder[k]));
         end
         repeat (3) @(negedge sdram_clk);
         fxReq = '0;
         repeat (3) @(negedge sdram_clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
